cc_fill_unit_wrap: RTL and testbench

- Parametrised successor of the cache-controller line fill path.
- Receives AXI R-channel beats, which arrive critical-word-first and wrap within the line. Assembles them into a full cache line and issues one SRAM write of tag, valid and data per line.
- Pops the miss-address FIFO at the first beat, so back-to-back fills run with no bubble.
- Also provides an early-restart critical-word output and an error/protocol-fault output. Sits between the memory R channel, the miss-address FIFO and the tag/data SRAM write port.

---
 rtl/cc_fill_pkg.sv | 43 ++++
 rtl/cc_line_buffer.sv | 52 +++++
 rtl/cc_fill_unit_wrap.sv | 194 +++++++++++++++++++
 tb/tb_cc_fill_unit_wrap.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_fill_pkg.sv
// Shared widths, state encoding and response decoding for the cache line fill path.
package cc_fill_pkg;

   // Bit of RRESP that flags SLVERR/DECERR.
   localparam int unsigned RESP_ERR = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } fill_state_e;

   function automatic int unsigned beats_f(input int unsigned data_w,
                                           input int unsigned line_bytes);
      return (line_bytes * 8) / data_w;
   endfunction

   function automatic int unsigned beat_w_f(input int unsigned data_w,
                                            input int unsigned line_bytes);
      return $clog2(beats_f(data_w, line_bytes));
   endfunction

   function automatic int unsigned off_w_f(input int unsigned line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int unsigned boff_w_f(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int unsigned tag_w_f(input int unsigned addr_w,
                                           input int unsigned index_w,
                                           input int unsigned line_bytes);
      return addr_w - index_w - off_w_f(line_bytes);
   endfunction

   // Pointer width, kept at least one bit so single-beat lines still have a legal index.
   function automatic int unsigned ptr_w_f(input int unsigned data_w,
                                           input int unsigned line_bytes);
      return (beats_f(data_w, line_bytes) > 1) ? beat_w_f(data_w, line_bytes) : 1;
   endfunction

endpackage

// File: rtl/cc_line_buffer.sv
// Beat-granular line assembly buffer with a merged flattened read port.
module cc_line_buffer #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned BEATS  = 8,
   parameter int unsigned PTR_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    wr_en,
   input  logic [PTR_W-1:0]        wr_idx,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    merge_en,
   input  logic                    merge_clr,
   input  logic [PTR_W-1:0]        merge_idx,
   input  logic [DATA_W-1:0]       merge_data,
   output logic [BEATS*DATA_W-1:0] rd_line
);

   logic [DATA_W-1:0] mem_q [BEATS];

   // Storage: clear drops stale beats of the previous line, the indexed write wins over it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < BEATS; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < BEATS; k++) begin
            if (wr_en && (wr_idx == PTR_W'(k))) begin
               mem_q[k] <= wr_data;
            end else if (clr) begin
               mem_q[k] <= '0;
            end
         end
      end
   end

   // Read port: the closing beat bypasses storage; merge_clr hides stored beats for a
   // line that closes on its first beat.
   always_comb begin
      rd_line = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (merge_en && (merge_idx == PTR_W'(k))) begin
            rd_line[k*DATA_W +: DATA_W] = merge_data;
         end else if (!merge_clr) begin
            rd_line[k*DATA_W +: DATA_W] = mem_q[k];
         end
      end
   end

endmodule

// File: rtl/cc_fill_unit_wrap.sv
// Critical-word-first wrapping line fill: assembles R beats into one SRAM line write.
module cc_fill_unit_wrap
   import cc_fill_pkg::*;
#(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned LINE_BYTES = 64,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned INDEX_W    = 9
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [DATA_W-1:0]                           mem_rdata_i,
   input  logic [1:0]                                  mem_rresp_i,
   input  logic                                        mem_rlast_i,
   input  logic                                        mem_rvalid_i,
   input  logic                                        mem_rready_i,
   input  logic                                        miss_addr_fifo_empty_i,
   input  logic [ADDR_W-1:0]                           miss_addr_fifo_rdata_i,
   output logic                                        miss_addr_fifo_rden_o,
   output logic                                        wren_o,
   output logic [INDEX_W-1:0]                          waddr_o,
   output logic [tag_w_f(ADDR_W, INDEX_W, LINE_BYTES):0] wdata_tag_o,
   output logic [LINE_BYTES*8-1:0]                     wdata_data_o,
   output logic                                        crit_valid_o,
   output logic [DATA_W-1:0]                           crit_data_o,
   output logic                                        err_o
);

   localparam int unsigned BEATS  = beats_f(DATA_W, LINE_BYTES);
   localparam int unsigned OFF_W  = off_w_f(LINE_BYTES);
   localparam int unsigned BOFF_W = boff_w_f(DATA_W);
   localparam int unsigned TAG_W  = tag_w_f(ADDR_W, INDEX_W, LINE_BYTES);
   localparam int unsigned PTR_W  = ptr_w_f(DATA_W, LINE_BYTES);
   localparam int unsigned CNT_W  = $clog2(BEATS + 1);

   fill_state_e             state_q, state_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    err_q, err_d;

   logic                    wren_q, crit_valid_q, err_pulse_q;
   logic [INDEX_W-1:0]      waddr_q;
   logic [TAG_W:0]          tag_q;
   logic [LINE_BYTES*8-1:0] data_q;
   logic [DATA_W-1:0]       crit_q;

   logic                    accept, resp_err, pop, buf_clr, buf_wr, close, fault;
   logic                    crit_load, drop_err, early_last, missing_last;
   logic [PTR_W-1:0]        buf_idx, ptr_first, ptr_next;
   logic [LINE_BYTES*8-1:0] line_rd;
   logic                    unused_resp;

   assign accept      = mem_rvalid_i & mem_rready_i;
   assign resp_err    = mem_rresp_i[RESP_ERR];
   assign unused_resp = ^mem_rresp_i;
   // Beat slot of the critical word; modulo keeps it in range for non-power-of-two lines.
   assign ptr_first   = PTR_W'((miss_addr_fifo_rdata_i % ADDR_W'(LINE_BYTES)) >> BOFF_W);
   assign ptr_next    = (ptr_q == PTR_W'(BEATS - 1)) ? '0 : ptr_q + PTR_W'(1);

   // Next-state, buffer control and line-close decision.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      err_d        = err_q;
      pop          = 1'b0;
      buf_clr      = 1'b0;
      buf_wr       = 1'b0;
      buf_idx      = ptr_q;
      close        = 1'b0;
      crit_load    = 1'b0;
      drop_err     = 1'b0;
      fault        = 1'b0;
      early_last   = 1'b0;
      missing_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!miss_addr_fifo_empty_i) begin
                  pop       = 1'b1;
                  addr_d    = miss_addr_fifo_rdata_i;
                  ptr_d     = ptr_first;
                  cnt_d     = CNT_W'(1);
                  err_d     = resp_err;
                  buf_clr   = 1'b1;
                  buf_wr    = 1'b1;
                  buf_idx   = ptr_first;
                  crit_load = 1'b1;
                  close     = mem_rlast_i | (BEATS == 1);
                  state_d   = FILL;
               end else begin
                  // No miss to attribute the burst to: flag it and swallow the rest.
                  drop_err = 1'b1;
                  state_d  = mem_rlast_i ? IDLE : DRAIN;
               end
            end
         end
         FILL: begin
            if (accept) begin
               ptr_d   = ptr_next;
               cnt_d   = cnt_q + CNT_W'(1);
               err_d   = err_q | resp_err;
               buf_wr  = 1'b1;
               buf_idx = ptr_next;
               close   = mem_rlast_i | (cnt_d == CNT_W'(BEATS));
            end
         end
         DRAIN: begin
            if (accept && mem_rlast_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (close) begin
         early_last   = mem_rlast_i & (cnt_d < CNT_W'(BEATS));
         missing_last = ~mem_rlast_i & (cnt_d == CNT_W'(BEATS));
         fault        = err_d | early_last | missing_last;
         state_d      = missing_last ? DRAIN : IDLE;
      end
   end

   cc_line_buffer #(
      .DATA_W (DATA_W),
      .BEATS  (BEATS),
      .PTR_W  (PTR_W)
   ) u_line_buffer (
      .clk        (clk),
      .rst        (rst),
      .clr        (buf_clr),
      .wr_en      (buf_wr),
      .wr_idx     (buf_idx),
      .wr_data    (mem_rdata_i),
      .merge_en   (close),
      .merge_clr  (buf_clr),
      .merge_idx  (buf_idx),
      .merge_data (mem_rdata_i),
      .rd_line    (line_rd)
   );

   // Fill-tracking state: FSM, wrap pointer, beat count, captured miss and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   // Output registers, separate from the buffer so a new line can start during the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wren_q       <= 1'b0;
         crit_valid_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         waddr_q      <= '0;
         tag_q        <= '0;
         data_q       <= '0;
         crit_q       <= '0;
      end else begin
         wren_q       <= close;
         crit_valid_q <= crit_load;
         err_pulse_q  <= (close & fault) | drop_err;
         if (crit_load) begin
            crit_q <= mem_rdata_i;
         end
         if (close) begin
            waddr_q <= addr_d[OFF_W +: INDEX_W];
            tag_q   <= {~fault, addr_d[ADDR_W-1 -: TAG_W]};
            data_q  <= line_rd;
         end
      end
   end

   assign miss_addr_fifo_rden_o = pop;
   assign wren_o                = wren_q;
   assign waddr_o               = waddr_q;
   assign wdata_tag_o           = tag_q;
   assign wdata_data_o          = data_q;
   assign crit_valid_o          = crit_valid_q;
   assign crit_data_o           = crit_q;
   assign err_o                 = err_pulse_q;

endmodule

// File: tb/tb_cc_fill_unit_wrap.sv
// Randomized bench for the line fill unit over three geometries, checked against a
// burst-level model of the expected pops, critical words, error pulses and line writes.
module tb_cc_fill_unit_wrap;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int G   = g;
      localparam int DW  = (g == 1) ? 128 : (g == 2) ? 32 : 64;
      localparam int LB  = (g == 2) ? 32 : 64;
      localparam int LW  = LB * 8;
      localparam int NB  = LW / DW;
      localparam int OFF = $clog2(LB);
      localparam int TW  = 32 - 9 - OFF;

      logic          rst, rvalid, rready, rlast, fempty, rden, wren, crit_v, err;
      logic [DW-1:0] rdata, crit_d;
      logic [1:0]    rresp;
      logic [31:0]   faddr;
      logic [8:0]    waddr;
      logic [TW:0]   wtag;
      logic [LW-1:0] wdat;

      cc_fill_unit_wrap #(
         .DATA_W     (DW),
         .LINE_BYTES (LB),
         .ADDR_W     (32),
         .INDEX_W    (9)
      ) dut (
         .clk                    (clk),
         .rst                    (rst),
         .mem_rdata_i            (rdata),
         .mem_rresp_i            (rresp),
         .mem_rlast_i            (rlast),
         .mem_rvalid_i           (rvalid),
         .mem_rready_i           (rready),
         .miss_addr_fifo_empty_i (fempty),
         .miss_addr_fifo_rdata_i (faddr),
         .miss_addr_fifo_rden_o  (rden),
         .wren_o                 (wren),
         .waddr_o                (waddr),
         .wdata_tag_o            (wtag),
         .wdata_data_o           (wdat),
         .crit_valid_o           (crit_v),
         .crit_data_o            (crit_d),
         .err_o                  (err)
      );

      int            exp_pop[$], obs_pop[$], exp_err[$], obs_err[$];
      int            exp_crit_c[$], obs_crit_c[$], exp_wr_c[$], obs_wr_c[$];
      logic [DW-1:0] exp_crit_d[$], obs_crit_d[$];
      logic [8:0]    exp_wr_i[$], obs_wr_i[$];
      logic [TW:0]   exp_wr_t[$], obs_wr_t[$];
      logic [LW-1:0] exp_wr_d[$], obs_wr_d[$];

      // Registered outputs are sampled mid-cycle and stamped with the edge that produced them.
      always @(negedge clk) begin
         if (wren === 1'b1) begin
            obs_wr_c.push_back(cyc);
            obs_wr_i.push_back(waddr);
            obs_wr_t.push_back(wtag);
            obs_wr_d.push_back(wdat);
         end
         if (crit_v === 1'b1) begin
            obs_crit_c.push_back(cyc);
            obs_crit_d.push_back(crit_d);
         end
         if (err === 1'b1) obs_err.push_back(cyc);
      end

      function automatic logic [DW-1:0] rand_data();
         logic [DW-1:0] x;
         for (int k = 0; k < DW; k += 32) x[k +: 32] = $urandom();
         return x;
      endfunction

      // One cycle of R-channel stimulus; e is the clock edge at which it is sampled.
      task automatic drive(input logic v, input logic rd, input logic [DW-1:0] d,
                           input logic [1:0] rs, input logic last, input logic setf,
                           input logic fe, input logic [31:0] fa,
                           output logic acc, output int e);
         @(negedge clk);
         rvalid = v;
         rready = rd;
         rdata  = d;
         rresp  = rs;
         rlast  = last;
         if (setf) begin
            fempty = fe;
            faddr  = fa;
         end
         #1;
         e   = cyc + 1;
         acc = v & rd;
         if (rden === 1'b1) obs_pop.push_back(e);
      endtask

      task automatic idle();
         logic acc;
         int e;
         drive(1'b0, 1'($urandom_range(0, 1)), rand_data(), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0, acc, e);
      endtask

      task automatic check_zero_outputs(input string what);
         check($sformatf("c%0d %s wren", G, what), 512'(wren), 512'(0));
         check($sformatf("c%0d %s err", G, what), 512'(err), 512'(0));
         check($sformatf("c%0d %s crit_valid", G, what), 512'(crit_v), 512'(0));
         check($sformatf("c%0d %s rden", G, what), 512'(rden), 512'(0));
         check($sformatf("c%0d %s waddr", G, what), 512'(waddr), 512'(0));
         check($sformatf("c%0d %s tag", G, what), 512'(wtag), 512'(0));
         check($sformatf("c%0d %s data", G, what), 512'(wdat), 512'(0));
         check($sformatf("c%0d %s crit_data", G, what), 512'(crit_d), 512'(0));
      endtask

      // Drives a burst of n beats (rlast on the last one), optionally cut short by a reset
      // after 'cut' beats, then predicts the unit's externally visible events.
      task automatic send_burst(input int n, input logic emp, input logic [31:0] addr,
                                input int err_beat, input int cut);
         logic [DW-1:0] d [16];
         logic          er [16];
         int            e [16];
         int            nacc, c, start;
         logic          acc, valid;
         logic [LW-1:0] line;
         nacc = (cut > 0) ? cut : n;
         for (int i = 0; i < nacc; i++) begin
            d[i]  = rand_data();
            er[i] = (i == err_beat);
            if ($urandom_range(0, 4) == 0) idle();
            do begin
               drive(1'b1, 1'($urandom_range(0, 3) != 0), d[i],
                     {er[i], 1'($urandom_range(0, 1))}, (i == n - 1), (i == 0), emp, addr,
                     acc, e[i]);
            end while (!acc);
         end
         if (cut > 0) begin
            @(negedge clk);
            #2;
            rst    = 1'b1;
            rvalid = 1'b0;
            #1;
            check_zero_outputs("mid_reset");
            @(negedge clk);
            rst = 1'b0;
         end
         if (emp) begin
            exp_err.push_back(e[0]);
            return;
         end
         exp_pop.push_back(e[0]);
         exp_crit_c.push_back(e[0]);
         exp_crit_d.push_back(d[0]);
         if (cut > 0) return;
         c     = (n < NB) ? n : NB;
         start = (addr % LB) / (DW / 8);
         line  = '0;
         valid = (n == NB);
         for (int i = 0; i < c; i++) begin
            line[((start + i) % NB) * DW +: DW] = d[i];
            if (er[i]) valid = 1'b0;
         end
         exp_wr_c.push_back(e[c - 1]);
         exp_wr_i.push_back(addr[OFF +: 9]);
         exp_wr_t.push_back({valid, addr[31 -: TW]});
         exp_wr_d.push_back(line);
         if (!valid) exp_err.push_back(e[c - 1]);
      endtask

      task automatic compare_all();
         check($sformatf("c%0d pop_count", G), 512'(obs_pop.size()), 512'(exp_pop.size()));
         for (int i = 0; i < exp_pop.size() && i < obs_pop.size(); i++)
            check($sformatf("c%0d pop_cycle[%0d]", G, i), 512'(obs_pop[i]), 512'(exp_pop[i]));
         check($sformatf("c%0d err_count", G), 512'(obs_err.size()), 512'(exp_err.size()));
         for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++)
            check($sformatf("c%0d err_cycle[%0d]", G, i), 512'(obs_err[i]), 512'(exp_err[i]));
         check($sformatf("c%0d crit_count", G), 512'(obs_crit_c.size()),
               512'(exp_crit_c.size()));
         for (int i = 0; i < exp_crit_c.size() && i < obs_crit_c.size(); i++) begin
            check($sformatf("c%0d crit_cycle[%0d]", G, i), 512'(obs_crit_c[i]),
                  512'(exp_crit_c[i]));
            check($sformatf("c%0d crit_data[%0d]", G, i), 512'(obs_crit_d[i]),
                  512'(exp_crit_d[i]));
         end
         check($sformatf("c%0d write_count", G), 512'(obs_wr_c.size()), 512'(exp_wr_c.size()));
         for (int i = 0; i < exp_wr_c.size() && i < obs_wr_c.size(); i++) begin
            check($sformatf("c%0d wr_cycle[%0d]", G, i), 512'(obs_wr_c[i]), 512'(exp_wr_c[i]));
            check($sformatf("c%0d wr_index[%0d]", G, i), 512'(obs_wr_i[i]), 512'(exp_wr_i[i]));
            check($sformatf("c%0d wr_tag[%0d]", G, i), 512'(obs_wr_t[i]), 512'(exp_wr_t[i]));
            check($sformatf("c%0d wr_data[%0d]", G, i), 512'(obs_wr_d[i]), 512'(exp_wr_d[i]));
         end
      endtask

      initial begin
         int k, n, cut;
         rst    = 1'b1;
         rvalid = 1'b0;
         rready = 1'b0;
         rdata  = '0;
         rresp  = 2'b00;
         rlast  = 1'b0;
         fempty = 1'b1;
         faddr  = '0;
         repeat (2) @(negedge clk);
         #1;
         check_zero_outputs("reset");
         rst = 1'b0;
         // Directed sequence: reference line, back-to-back line, error beat, early rlast,
         // over-long burst followed by a normal line, empty FIFO, reset mid-line.
         send_burst(NB, 1'b0, 32'h0001_2368, -1, 0);
         send_burst(NB, 1'b0, $urandom(), -1, 0);
         send_burst(NB, 1'b0, $urandom(), 2, 0);
         send_burst((NB > 5) ? 5 : NB - 1, 1'b0, $urandom(), -1, 0);
         send_burst(NB + 2, 1'b0, $urandom(), -1, 0);
         send_burst(NB, 1'b0, $urandom(), -1, 0);
         send_burst(2, 1'b1, $urandom(), -1, 0);
         send_burst(NB, 1'b0, $urandom(), -1, (NB > 4) ? 4 : NB - 1);
         send_burst(NB, 1'b0, $urandom(), -1, 0);
         for (int s = 0; s < 40; s++) begin
            k = $urandom_range(0, 9);
            case (k)
               4: send_burst(NB, 1'b0, $urandom(), $urandom_range(0, NB - 1), 0);
               5: send_burst($urandom_range(1, NB - 1), 1'b0, $urandom(), -1, 0);
               6: send_burst(NB + $urandom_range(1, 3), 1'b0, $urandom(), -1, 0);
               7: send_burst($urandom_range(1, 3), 1'b1, $urandom(), -1, 0);
               8: begin
                  cut = $urandom_range(1, NB - 1);
                  send_burst(NB, 1'b0, $urandom(), -1, cut);
               end
               9: begin
                  n = $urandom_range(1, NB + 2);
                  send_burst(n, 1'b0, $urandom(), $urandom_range(0, n - 1), 0);
               end
               default: send_burst(NB, 1'b0, $urandom(), -1, 0);
            endcase
         end
         repeat (4) idle();
         compare_all();
         done_cnt++;
      end
   end

   initial begin
      for (int i = 0; i < 60000; i++) begin
         if (done_cnt == 3) break;
         @(posedge clk);
      end
      check("configs_done", 512'(done_cnt), 512'(3));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
